// File: rtl/serial_to_parallel_rx.sv
// rtl/serial_to_parallel_rx.sv - comma-aligned serial-to-parallel byte receiver
//
// Purpose:
//   Shifts a serial MSB-first bit stream into bytes, hunts for the COM
//   symbol, and declares the lane active once BC_COUNT consecutive COM
//   symbols are seen on the same byte boundary. After that, every byte
//   boundary updates data_out, and non-COM bytes raise valid_out for one cycle.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   data_in   in   serial bit, MSB of each byte first
//   data_out  out  [7:0] last complete byte seen while active
//   valid_out out  one-cycle pulse when data_out holds a payload (non-COM) byte
//   active    out  lane aligned; sticky until reset

module serial_to_parallel_rx #(
  parameter logic [7:0] COM      = 8'hBC,
  parameter int         BC_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int CW = (BC_COUNT < 2) ? 1 : $clog2(BC_COUNT + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t          state_q,     state_d;
  // Only the seven most recent bits are kept: the eighth would shift out
  // before it could be read, since every byte decision looks at nxt.
  logic [6:0]      sr_q,        sr_d;
  logic [2:0]      bit_cnt_q,   bit_cnt_d;
  logic [CW-1:0]   com_cnt_q,   com_cnt_d;
  logic [7:0]      data_out_q,  data_out_d;
  logic            valid_out_q, valid_out_d;
  logic            active_q,    active_d;

  logic [7:0]      nxt;
  logic            is_com;
  logic            boundary;
  logic [CW-1:0]   com_cnt_inc;

  assign nxt         = {sr_q, data_in};
  assign is_com      = (nxt == COM);
  assign boundary    = (bit_cnt_q == 3'd7);
  assign com_cnt_inc = com_cnt_q + CW'(1);

  // State register (all flops)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SEARCH;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      com_cnt_q   <= '0;
      data_out_q  <= 8'h00;
      valid_out_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      com_cnt_q   <= com_cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      active_q    <= active_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH: begin
        if (is_com) begin
          state_d = (BC_COUNT <= 1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (!is_com) begin
            state_d = SEARCH;
          end else if (com_cnt_inc == CW'(BC_COUNT)) begin
            state_d = ACTIVE;
          end
        end
      end
      ACTIVE:  state_d = ACTIVE;
      default: state_d = SEARCH;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    sr_d        = nxt[6:0];
    bit_cnt_d   = bit_cnt_q;
    com_cnt_d   = com_cnt_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    active_d    = (state_d == ACTIVE);
    case (state_q)
      SEARCH: begin
        // A match here is itself the first aligned COM; counting restarts
        // from bit 0 of the following byte.
        bit_cnt_d = 3'd0;
        com_cnt_d = is_com ? CW'(1) : '0;
      end
      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_cnt_inc;
          end else begin
            bit_cnt_d = 3'd0;
            com_cnt_d = '0;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          data_out_d  = nxt;
          valid_out_d = !is_com;
        end
      end
      default: begin
        bit_cnt_d = 3'd0;
        com_cnt_d = '0;
      end
    endcase
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign active    = active_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb/tb_serial_to_parallel_rx.sv - self-checking bench for serial_to_parallel_rx

module tb_serial_to_parallel_rx;

  localparam logic [7:0] COM = 8'hBC;
  localparam int         BC  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out, data_out1;
  logic       valid_out, valid_out1;
  logic       active, active1;

  serial_to_parallel_rx #(.COM(COM), .BC_COUNT(BC)) u_dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .active(active)
  );

  serial_to_parallel_rx #(.COM(COM), .BC_COUNT(1)) u_dut1 (
    .clk(clk), .reset(reset), .data_in(data_in),
    .data_out(data_out1), .valid_out(valid_out1), .active(active1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  logic [7:0] pq[$];
  int         pc[$];
  logic [7:0] p1q[$];

  // Model: byte-window view of the stream since reset release.
  logic [7:0] m_win;
  int         m_n, m_cand, m_cnt;
  bit         m_locked;
  logic [7:0] exp_data;
  bit         exp_valid, exp_active;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_win = 8'h00; m_n = 0; m_cand = -1; m_cnt = 0; m_locked = 0;
    exp_data = 8'h00; exp_valid = 0; exp_active = 0;
  endtask

  // Expected outputs after the edge that samples bit b.
  task automatic model_step(input bit b);
    m_win = {m_win[6:0], b};
    exp_valid = 0;
    if (m_cand < 0) begin
      if (m_win == COM) begin
        m_cand = m_n; m_cnt = 1;
        if (m_cnt == BC) m_locked = 1;
      end
    end else if ((m_n - m_cand) % 8 == 0) begin
      if (m_locked) begin
        exp_data  = m_win;
        exp_valid = (m_win != COM);
      end else if (m_win == COM) begin
        m_cnt++;
        if (m_cnt == BC) m_locked = 1;
      end else begin
        m_cand = -1; m_cnt = 0;
      end
    end
    exp_active = m_locked;
    m_n++;
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (chk_en) begin
      chk("data_out",  int'(data_out),  int'(exp_data));
      chk("valid_out", int'(valid_out), int'(exp_valid));
      chk("active",    int'(active),    int'(exp_active));
      if (valid_out)  begin pq.push_back(data_out); pc.push_back(cyc); end
      if (valid_out1) p1q.push_back(data_out1);
    end
  end

  task automatic send_bit(input bit b);
    @(negedge clk);
    data_in = b;
    if (reset) model_step(b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_coms();
    for (int k = 0; k < 4; k++) send_byte(COM);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic hold_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      data_in = 1'($urandom);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    data_in = 1'b0;
    model_step(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    hold_reset();
    release_reset();
  endtask

  task automatic clear_q();
    pq.delete(); pc.delete(); p1q.delete();
  endtask

  initial begin
    model_reset();
    chk_en = 1'b1;

    // Reset held with arbitrary input
    hold_reset();
    chk("rst_data",   int'(data_out),  0);
    chk("rst_valid",  int'(valid_out), 0);
    chk("rst_active", int'(active),    0);
    release_reset();

    // Alignment: 4xBC then FF F4 E8
    clear_q();
    for (int k = 0; k < 3; k++) send_byte(COM);
    for (int i = 7; i >= 1; i--) send_bit(COM[i]);
    settle();
    chk("act_bit31", int'(active), 0);
    chk("bc1_active", int'(active1), 1);
    send_bit(COM[0]);
    settle();
    chk("act_bit32", int'(active), 1);
    send_byte(8'hFF); send_byte(8'hF4); send_byte(8'hE8);
    settle();
    chk("align_npulse", pq.size(), 3);
    if (pq.size() == 3) begin
      chk("align_b0", int'(pq[0]), 8'hFF);
      chk("align_b1", int'(pq[1]), 8'hF4);
      chk("align_b2", int'(pq[2]), 8'hE8);
      chk("align_gap0", pc[1] - pc[0], 8);
      chk("align_gap1", pc[2] - pc[1], 8);
    end
    chk("bc1_npulse", p1q.size(), 3);
    if (p1q.size() == 3) chk("bc1_b0", int'(p1q[0]), 8'hFF);

    // Offset: junk 101, 4xBC, 7F
    do_reset();
    clear_q();
    send_bit(1); send_bit(0); send_bit(1);
    send_coms();
    send_byte(8'h7F);
    settle();
    chk("off_npulse", pq.size(), 1);
    if (pq.size() == 1) chk("off_b0", int'(pq[0]), 8'h7F);
    chk("off_active", int'(active), 1);

    // Broken alignment: BC BC 55, 4xBC, 1C
    do_reset();
    clear_q();
    send_byte(COM); send_byte(COM); send_byte(8'h55);
    settle();
    chk("brk_active", int'(active), 0);
    chk("brk_npulse0", pq.size(), 0);
    send_coms();
    send_byte(8'h1C);
    settle();
    chk("brk_npulse", pq.size(), 1);
    if (pq.size() == 1) chk("brk_b0", int'(pq[0]), 8'h1C);

    // Idle in stream: FF BC 8C after lock
    do_reset();
    send_coms();
    clear_q();
    send_byte(8'hFF);
    send_byte(COM);
    settle();
    chk("idle_data", int'(data_out), 8'hBC);
    chk("idle_valid", int'(valid_out), 0);
    send_byte(8'h8C);
    settle();
    chk("idle_npulse", pq.size(), 2);
    if (pq.size() == 2) begin
      chk("idle_b0", int'(pq[0]), 8'hFF);
      chk("idle_b1", int'(pq[1]), 8'h8C);
    end
    chk("idle_active", int'(active), 1);

    // Reset mid-payload, between clock edges
    do_reset();
    send_coms();
    clear_q();
    send_bit(1); send_bit(0); send_bit(1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("mid_active", int'(active), 0);
    chk("mid_valid", int'(valid_out), 0);
    chk("mid_data", int'(data_out), 0);
    hold_reset();
    release_reset();
    send_coms();
    send_byte(8'hD4);
    settle();
    chk("mid_npulse", pq.size(), 1);
    if (pq.size() == 1) chk("mid_b0", int'(pq[0]), 8'hD4);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_rx.md
SERIAL_TO_PARALLEL_RX -- requirements
Module: serial_to_parallel_rx

Interface
REQ-001 The block SHALL expose parameter COM, default 8'hBC, the comma/idle symbol used for alignment.
REQ-002 The block SHALL expose parameter BC_COUNT, default 4, the number of consecutive aligned COM symbols required before the lane goes active.
REQ-003 clk  input  1  single clock; all sampling and state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 data_in  input  1  serial bit stream, MSB of each byte first, one bit per clk cycle.
REQ-006 data_out  output  8  last complete byte assembled after alignment.
REQ-007 valid_out  output  1  data_out holds a non-COM payload byte; high for exactly one cycle per such byte.
REQ-008 active  output  1  lane is aligned and delivering payload.

Function
REQ-009 The block SHALL shift data_in into an 8-bit register every cycle: sr <= {sr[6:0], data_in}; nxt denotes {sr[6:0], data_in}.
REQ-010 The FSM SHALL have states SEARCH, ALIGN and ACTIVE, plus a 3-bit bit counter bit_cnt and a COM counter com_cnt sized for BC_COUNT.
REQ-011 SEARCH: each cycle nxt is compared with COM; on a match -> ALIGN, com_cnt=1, bit_cnt=0; otherwise remain in SEARCH with bit_cnt and com_cnt unchanged at 0.
REQ-012 ALIGN and ACTIVE: bit_cnt SHALL increment every cycle, wrapping 7->0; a byte boundary is the cycle where bit_cnt==7, and nxt is then the complete byte.
REQ-013 ALIGN at a boundary with nxt==COM: com_cnt increments; if the result equals BC_COUNT -> ACTIVE.
REQ-014 ALIGN at a boundary with nxt!=COM: -> SEARCH, com_cnt=0, bit_cnt=0; the failing byte is not re-searched at a shifted offset.
REQ-015 ACTIVE at every boundary: data_out <= nxt; valid_out <= 1 if nxt!=COM, else 0.
REQ-016 valid_out SHALL be 0 in every cycle that is not the cycle immediately after an ACTIVE boundary; payload latency is 1 clk from the sample of the byte's last bit.
REQ-017 data_out SHALL hold its value between boundaries and SHALL NOT update in SEARCH or ALIGN.
REQ-018 active SHALL be registered, going to 1 on the edge that enters ACTIVE and remaining 1 until reset; ACTIVE has no exit other than reset.
REQ-019 With BC_COUNT==1, the first COM match in SEARCH SHALL go directly to ACTIVE.
REQ-020 A COM byte appearing in ACTIVE SHALL be treated as idle: no valid_out, and alignment is kept.

Reset
REQ-021 Asserting reset (low) SHALL immediately force state=SEARCH, sr=0, bit_cnt=0, com_cnt=0, data_out=8'h00, valid_out=0 and active=0, independent of clk.
REQ-022 Reset asserted mid-byte or mid-alignment SHALL discard all partial data; after release, alignment restarts from SEARCH on the next rising edge.
REQ-023 On the first rising edge after reset deasserts, the block SHALL sample data_in normally.

Verification
REQ-024 Reset: reset=0 with arbitrary data_in -> data_out=00, valid_out=0 and active=0 throughout; outputs also clear when reset falls between clock edges.
REQ-025 Alignment: 4xBC (32 bits), then bytes FF, F4, E8 -> active rises 1 cycle after the 32nd bit; valid_out pulses 3 times with data_out FF, F4, E8, each 8 cycles apart.
REQ-026 Offset: 3 junk bits 101, then 4xBC, then 7F -> alignment locks on the shifted boundary; 7F is delivered correctly.
REQ-027 Broken alignment: BC, BC, 55, then 4xBC, then 1C -> state returns to SEARCH after 55 with active=0 and no valid_out; active rises after the later 4xBC; 1C is then delivered.
REQ-028 Idle in stream: after lock, send FF, BC, 8C -> valid_out pulses for FF and 8C only; data_out shows BC with valid_out=0 at the middle boundary; active stays 1.
REQ-029 Reset mid-operation: pull reset low 3 bits into a payload byte after lock -> active=0 and valid_out=0 immediately; after release, 4xBC and D4 -> D4 delivered.
